// File: rtl/rnd_bounded_fifo.sv
// rnd_bounded_fifo: bounded uniform sampler (mask + reject) feeding a DEPTH-entry FIFO; define RND_REJECT_CNT_EN to build the rejection counter
module rnd_bounded_fifo #(
    parameter int DEPTH = 4,
    parameter int OW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   rnd,
    input  logic          rnd_valid,
    input  logic          en,
    input  logic [15:0]   bound,
    input  logic          bound_load,
    output logic [OW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   reject_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t         state_q, state_d;
    logic [15:0]    bound_q, mask_q, mask_d, cand;
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [AW:0]    count_q, count_d;
    logic [OW-1:0]  mem_q [DEPTH];
    logic           accept, sample, push, pop;
    logic           unused_rnd_hi;

    assign unused_rnd_hi = ^rnd[31:16];
    assign out_valid     = count_q != '0;
    assign out_data      = out_valid ? mem_q[rptr_q] : '0;

    // Next state, mask for a newly loaded bound, and the FIFO push/pop decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = en ? RUN : IDLE;
            LOAD:    state_d = en ? RUN : IDLE;
            RUN:     state_d = en ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
        state_d = bound_load ? LOAD : state_d;
        mask_d  = bound - 16'd1;
        mask_d  = mask_d | (mask_d >> 1);
        mask_d  = mask_d | (mask_d >> 2);
        mask_d  = mask_d | (mask_d >> 4);
        mask_d  = mask_d | (mask_d >> 8);
        cand    = rnd[15:0] & mask_q;
        accept  = (bound_q == 16'd0) || (cand < bound_q);
        sample  = (state_q == RUN) && rnd_valid && !bound_load;
        pop     = out_valid && out_ready;
        push    = sample && accept && ((count_q != FULL) || pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Control state, latched bound/mask and FIFO pointers; a bound load flushes the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bound_q <= '0;
            mask_q  <= 16'hFFFF;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (bound_load) begin
                bound_q <= bound;
                mask_q  <= mask_d;
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                wptr_q  <= wptr_q + AW'(push);
                rptr_q  <= rptr_q + AW'(pop);
                count_q <= count_d;
            end
        end
    end

    // FIFO storage; contents are only visible while count is non-zero
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= cand;
    end

`ifdef RND_REJECT_CNT_EN
    logic [15:0] rej_q;

    // Saturating count of candidates rejected while running; a new bound restarts it
    always_ff @(posedge clk) begin
        if (reset || bound_load) rej_q <= '0;
        else if (sample && !accept && rej_q != 16'hFFFF) rej_q <= rej_q + 16'd1;
    end

    assign reject_cnt = rej_q;
`else
    assign reject_cnt = '0;
`endif

endmodule

// File: tb/tb_rnd_bounded_fifo.sv
// tb_rnd_bounded_fifo: directed vector table, corner sequences and randomized run against a queue model
module tb_rnd_bounded_fifo;
    localparam int DEPTH  = 4;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
`ifdef RND_REJECT_CNT_EN
    localparam bit REJ_EN = 1'b1;
`else
    localparam bit REJ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, rnd_valid, en, bound_load, out_valid, out_ready;
    logic [31:0] rnd;
    logic [15:0] bound, out_data, reject_cnt;
    int          vectors = 0;
    int          miscompares = 0;

    int q[$];
    int m_bound, m_mode, m_rej;

    typedef struct {
        bit          rst, en, bl;
        logic [15:0] bnd;
        bit          rv;
        logic [15:0] rn;
        bit          rdy;
        bit          ev;
        logic [15:0] ed;
        logic [15:0] er;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    rnd_bounded_fifo #(.DEPTH(DEPTH), .OW(16)) dut (
        .clk(clk), .reset(reset), .rnd(rnd), .rnd_valid(rnd_valid), .en(en),
        .bound(bound), .bound_load(bound_load), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .reject_cnt(reject_cnt)
    );

    function automatic int mask_of(int b);
        int m = 0;
        if (b == 0) return 65535;
        while (m < b - 1) m = m * 2 + 1;
        return m;
    endfunction

    task automatic model_step();
        int  c;
        bit  popd;
        if (reset) begin
            q.delete(); m_bound = 0; m_mode = M_IDLE; m_rej = 0;
            return;
        end
        popd = q.size() > 0 && out_ready;
        if (bound_load) begin
            q.delete(); m_bound = int'(bound); m_rej = 0; m_mode = M_LOAD;
            return;
        end
        if (popd) void'(q.pop_front());
        if (m_mode == M_RUN && rnd_valid) begin
            c = int'(rnd[15:0]) & mask_of(m_bound);
            if (m_bound == 0 || c < m_bound) begin
                if (q.size() < DEPTH) q.push_back(c);
            end else if (m_rej < 65535) m_rej++;
        end
        m_mode = en ? M_RUN : M_IDLE;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input bit r, input bit e, input bit bl, input logic [15:0] b,
                       input bit rv, input logic [31:0] rn, input bit rdy);
        reset = r; en = e; bound_load = bl; bound = b;
        rnd_valid = rv; rnd = rn; out_ready = rdy;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(int r, int e, int bl, int b, int rv, int rn, int rdy,
                                int ev, int ed, int er);
        vec_t v;
        v.rst = r != 0; v.en = e != 0; v.bl = bl != 0; v.bnd = 16'(b);
        v.rv = rv != 0; v.rn = 16'(rn); v.rdy = rdy != 0;
        v.ev = ev != 0; v.ed = 16'(ed); v.er = REJ_EN ? 16'(er) : 16'd0;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [15:0] lst[3];
        set(1, 0, 0, 0, 0, 0, 0);
        // rst en bl bnd rv rn rdy | valid data rej
        add(1, 0, 0,  0, 0, 0,       0,  0, 0,       0);
        add(1, 0, 0,  0, 0, 0,       0,  0, 0,       0);
        add(0, 1, 0,  0, 0, 0,       0,  0, 0,       0);
        add(0, 1, 0,  0, 1, 'h1234,  0,  1, 'h1234,  0);
        add(0, 1, 0,  0, 0, 0,       1,  0, 0,       0);
        add(0, 1, 1, 10, 0, 0,       1,  0, 0,       0);
        add(0, 1, 0, 10, 1, 3,       1,  0, 0,       0);
        add(0, 1, 0, 10, 1, 5,       1,  1, 5,       0);
        add(0, 1, 0, 10, 1, 12,      1,  0, 0,       1);
        add(0, 1, 0, 10, 1, 9,       1,  1, 9,       1);
        add(0, 1, 0, 10, 0, 0,       1,  0, 0,       1);
        add(0, 1, 0, 10, 1, 'hFFF3,  1,  1, 3,       1);
        add(0, 1, 0, 10, 1, 'h001B,  1,  0, 0,       2);
        add(0, 1, 1,  1, 0, 0,       1,  0, 0,       0);
        add(0, 1, 0,  1, 1, 'hABCD,  1,  0, 0,       0);
        add(0, 1, 0,  1, 1, 'hFFFF,  1,  1, 0,       0);
        add(0, 1, 0,  1, 1, 'h1234,  1,  1, 0,       0);
        add(0, 0, 0,  1, 1, 'h5555,  1,  1, 0,       0);
        add(0, 0, 0,  1, 1, 'h7777,  1,  0, 0,       0);
        foreach (tbl[i]) begin
            set(tbl[i].rst, tbl[i].en, tbl[i].bl, tbl[i].bnd, tbl[i].rv,
                {16'hDEAD, tbl[i].rn}, tbl[i].rdy);
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d_rej", i), 32'(reject_cnt), 32'(tbl[i].er));
        end

        // bound of 1 forces every sample to zero with nothing rejected
        set(0, 1, 0, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            set(0, 1, 0, 1, 1, $urandom, 1'($urandom_range(0, 1)));
            tick();
            chk("b1_data", 32'(out_data), 32'd0);
            chk("b1_rej", 32'(reject_cnt), 32'd0);
        end

        // Overflow: 6 samples into 4 entries, then pop-while-full accepts 7
        set(1, 0, 0, 0, 0, 0, 0); tick();
        set(0, 1, 0, 0, 0, 0, 0); tick();
        for (int i = 1; i <= 6; i++) begin
            set(0, 1, 0, 0, 1, 32'(i), 0);
            tick();
        end
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_head", 32'(out_data), 32'd1);
        set(0, 1, 0, 0, 1, 32'd7, 1); tick();
        chk("pushpop_head", 32'(out_data), 32'd2);
        lst = '{16'd3, 16'd4, 16'd7};
        set(0, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("drain%0d", i), 32'(out_data), 32'(lst[i]));
        end
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // bound_load with simultaneous pop flushes; LOAD takes no sample
        set(1, 0, 0, 0, 0, 0, 0); tick();
        set(0, 1, 0, 0, 0, 0, 0); tick();
        for (int i = 1; i <= 3; i++) begin
            set(0, 1, 0, 0, 1, 32'(i * 11), 0);
            tick();
        end
        chk("pre_flush_head", 32'(out_data), 32'd11);
        set(0, 1, 1, 0, 1, 32'd55, 1); tick();
        chk("flush_valid", 32'(out_valid), 32'd0);
        set(0, 1, 0, 0, 1, 32'd66, 1); tick();
        chk("load_nosample", 32'(out_valid), 32'd0);
        set(0, 1, 0, 0, 1, 32'd77, 1); tick();
        chk("run_after_load", 32'(out_data), 32'd77);

        // Reset mid-stream discards contents; no output the first cycle after release
        set(0, 1, 0, 0, 1, 32'd88, 0); tick();
        chk("mid_valid", 32'(out_valid), 32'd1);
        set(1, 1, 0, 0, 1, 32'd1, 0); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        set(0, 1, 0, 0, 1, 32'd2, 0); tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        set(0, 1, 0, 0, 1, 32'd3, 0); tick();
        chk("post_rst_data", 32'(out_data), 32'd3);

        // Randomized traffic against the queue model
        set(1, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] b;
            case ($urandom_range(0, 7))
                0: b = 16'd0;
                1: b = 16'd1;
                2: b = 16'd2;
                3: b = 16'd3;
                4: b = 16'd10;
                5: b = 16'd17;
                6: b = 16'd256;
                default: b = 16'($urandom);
            endcase
            set($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 24) == 0, b, $urandom_range(0, 3) != 0,
                $urandom, 1'($urandom_range(0, 1)));
            tick();
            chk("rnd_valid_out", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_data", 32'(out_data), q.size() > 0 ? 32'(q[0]) : 32'd0);
            chk("rnd_rej", 32'(reject_cnt), REJ_EN ? 32'(m_rej) : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rnd_bounded_fifo.md
RND_BOUNDED_FIFO -- requirements
Module: rnd_bounded_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-002 SHALL have parameter OW, default 16, output sample width; fixed at 16 in this revision.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rnd  input  32  raw word from the upstream LFSR generator; only bits [15:0] are used.
REQ-006 SHALL have port rnd_valid  input  1  rnd holds a fresh word this cycle.
REQ-007 SHALL have port en  input  1  sampling enable.
REQ-008 SHALL have port bound  input  16  exclusive upper limit; 0 means 65536, the full range.
REQ-009 SHALL have port bound_load  input  1  one-cycle pulse that latches bound and flushes the FIFO.
REQ-010 SHALL have port out_data  output  16  head sample, in [0, bound).
REQ-011 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the head; a pop occurs when out_valid && out_ready.
REQ-013 SHALL have port reject_cnt  output  16  count of rejected samples (see Configuration).

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD and RUN.
- IDLE->RUN when en=1.
- RUN->IDLE when en=0.
- Any state->LOAD on bound_load; bound_load has priority over en.
- LOAD->RUN next cycle if en=1, else LOAD->IDLE.
REQ-015 In LOAD, SHALL register bound_r=bound and mask_r = smallest 2^k-1 >= bound_r-1.
- bound_r=0 gives mask_r=16'hFFFF.
- bound_r=1 gives mask_r=0.
REQ-016 In RUN with rnd_valid=1, SHALL form cand = rnd[15:0] & mask_r.
- Accept cand if bound_r=0 or cand < bound_r; otherwise reject it.
REQ-017 An accepted cand SHALL be written into the FIFO at that clock edge when space exists.
- Space exists when count<DEPTH, or count==DEPTH with a pop in the same cycle.
- out_valid SHALL rise the following cycle: one-cycle latency from sample to output.
REQ-018 An accepted cand that finds no space SHALL be dropped and SHALL NOT count as a rejection.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-021 out_data SHALL equal the head entry when out_valid=1, and 0 when out_valid=0.
REQ-022 bound_load SHALL empty the FIFO at that edge; a pop or push in the same cycle is discarded.
REQ-023 In IDLE and LOAD, SHALL take no samples; pops SHALL still be honoured in IDLE.
REQ-024 A rnd value of 0 or containing X SHALL be treated as an ordinary value; no special handling.

Reset
REQ-025 On reset=1 at a clock edge, SHALL set the following, with reset priority over every other input:
- state=IDLE, count=0, pointers=0
- bound_r=0, mask_r=16'hFFFF
- out_valid=0, out_data=0, reject_cnt=0
REQ-026 Reset asserted mid-stream SHALL discard all FIFO contents; no sample output SHALL appear in the first cycle after release.

Configuration
REQ-027 Macro RND_REJECT_CNT_EN SHALL gate the rejection counter.
- Defined: reject_cnt increments by 1 per rejected cand in RUN, saturates at 16'hFFFF, and clears on reset and on bound_load.
- Undefined: reject_cnt is tied to 0 and no counter logic is synthesised.

Verification
REQ-028 reset held 2 cycles -> out_valid=0, out_data=0, reject_cnt=0.
REQ-029 en=1, bound=0, rnd_valid=1, rnd=32'h0000_1234 -> one cycle later out_data=16'h1234, out_valid=1.
REQ-030 bound_load with bound=10, then rnd[15:0]=5, 12, 9 with out_ready=1 -> mask_r=15.
- Outputs are 5 then 9.
- With RND_REJECT_CNT_EN defined, reject_cnt=1.
REQ-031 DEPTH=4, out_ready=0, 6 accepted samples 1..6 -> count=4 and head=1.
- Then out_ready=1 with sample 7 -> outputs 1,2,3,4,7.
- The drop of 5 and 6 is confirmed.
REQ-032 FIFO holding 3 entries, bound_load pulse with simultaneous pop -> next cycle out_valid=0.
- The following cycle, state=RUN.
REQ-033 bound=1 with random rnd -> every output=0 and reject_cnt stays 0.
